pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed-depth pipeline shift buffer used between the IF/ID/EX/MEM/WB stages of the pipelined CPU.
- Adds per-stage valid bits, a stall boundary that freezes the younger stages and inserts a bubble, per-stage flush, an input-ready flag and a registered occupancy count.
- One instance carries one control or data field down the pipe. Enables load-use stalls and branch squash without hand-written per-field logic.

Parameters:
- WIDTH, 32, data bits per stage
- DEPTH, 4, number of stages (>=2); stage 0 is youngest, stage DEPTH-1 is oldest
- RESET_VAL, 0, data value loaded on reset, on a bubble and on a flush

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in  in  WIDTH  data entering stage 0
- in_valid  in  1  in carries a live instruction
- hold_upto  in  $clog2(DEPTH+1)  number of youngest stages frozen this cycle; 0 means all stages advance
- flush  in  DEPTH  per-stage kill mask, bit k = stage k
- out  out  [DEPTH][WIDTH]  packed stage contents, index k = stage k
- out_valid  out  DEPTH  per-stage valid
- in_ready  out  1  combinational; 1 iff effective hold is 0, meaning in is captured at the next edge
- occupancy  out  $clog2(DEPTH+1)  registered count of valid stages

Behaviour:
- Reset (reset=0): takes effect immediately with no clock edge needed. Every out[k] = RESET_VAL, out_valid = 0, occupancy = 0, and this is held while reset is low.
- Effective hold: H = min(hold_upto, DEPTH). Values above DEPTH saturate and are not an error.
- Next state of stage k at each rising edge, highest priority first:
  1. flush[k]=1: data = RESET_VAL, valid = 0.
  2. k < H: hold current data and valid.
  3. k == H and H >= 1: bubble, data = RESET_VAL, valid = 0.
  4. k == 0 (only when H = 0): load in and in_valid.
  5. Otherwise: load stage k-1 (data and valid).
- Stage DEPTH-1's old contents are discarded whenever it advances. There is no output handshake; the pipe never back-pressures from the old end.
- H = DEPTH: whole chain frozen. in is dropped and in_ready = 0.
- in_valid=0 with H=0: stage 0 loads in data with valid 0. The data is still captured, so it is visible for debug.
- Flush overrides hold: a held stage that is flushed is cleared.
- Flush overrides load: a stage that would receive data from stage k-1 is cleared instead.
- occupancy: registered popcount of the next-state valid vector, so it always equals popcount(out_valid) after any edge.
- Latency: a value on in with H=0 and no flush appears on out[k] k+1 edges later.
- No X propagation: all next-state muxes are fully specified. The hold_upto range is the only saturation point.

Decomposition:
- Package pipe_pkg:
  - function clamp_hold(hold, depth) returning the effective hold H
  - function popcount for the valid vector
  - stage-select enum {SEL_FLUSH, SEL_HOLD, SEL_BUBBLE, SEL_LOAD}
- Sub-module pipe_stage:
  - one WIDTH+1-bit register with async active-low reset
  - input mux driven by the stage-select enum
- Top level contains:
  - a generate loop of DEPTH pipe_stage instances
  - per-stage select logic
  - the occupancy register

Test Plan (DEPTH=4, WIDTH=32, RESET_VAL=0):
- Fill:
  - Stimulus: release reset, drive in = 0xA0,0xA1,0xA2,0xA3 with in_valid=1, hold=0, flush=0 for 4 edges.
  - Response: out[3]=0xA0, out[2]=0xA1, out[1]=0xA2, out[0]=0xA3; out_valid=4'b1111; occupancy=4; in_ready=1.
- Load-use stall:
  - Stimulus: from the filled state, hold_upto=2 for one edge with in=0xB0.
  - Response: during the hold cycle in_ready=0. After the edge: s0=0xA3, s1=0xA2 (held), s2=0 invalid (bubble), s3=0xA1; occupancy=3.
- Branch squash:
  - Stimulus: from the filled state, flush=4'b0011, hold=0, in=0xB0 valid.
  - Response: s0, s1 = 0 invalid; s2=0xA2, s3=0xA1; occupancy=2.
- Flush beats hold:
  - Stimulus: from the filled state, hold_upto=2, flush=4'b0001.
  - Response: s0=0 invalid, s1=0xA2 held, s2 bubble, s3=0xA1; occupancy=2.
- Saturation:
  - Stimulus: hold_upto=4, then hold_upto=7, one edge each.
  - Response: all stages unchanged both cycles; in_ready=0; occupancy unchanged.
- Async reset:
  - Stimulus: with the pipe full, drive reset low midway between edges.
  - Response: out=0, out_valid=0, occupancy=0 within the same timestep, before the next clk edge, and held until reset goes high.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
// Shared types and helpers for the parametrised pipeline stage chain.
// Supports chains up to 64 stages deep (popcount operand width).
package pipe_pkg;

   typedef enum logic [1:0] {
      SEL_FLUSH,
      SEL_HOLD,
      SEL_BUBBLE,
      SEL_LOAD
   } stage_sel_e;

   function automatic int unsigned clamp_hold(input int unsigned hold, input int unsigned depth);
      return (hold > depth) ? depth : hold;
   endfunction

   function automatic int unsigned popcount(input logic [63:0] vec);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         n += 32'(vec[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake/data bundle between a pipeline controller and one stage chain.
interface pipe_stage_chain_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned HW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]             in;
   logic                         in_valid;
   logic [HW-1:0]                hold_upto;
   logic [DEPTH-1:0]             flush;
   logic [DEPTH-1:0][WIDTH-1:0]  out;
   logic [DEPTH-1:0]             out_valid;
   logic                         in_ready;
   logic [HW-1:0]                occupancy;

   modport master (
      output in, in_valid, hold_upto, flush,
      input  out, out_valid, in_ready, occupancy
   );

   modport slave (
      input  in, in_valid, hold_upto, flush,
      output out, out_valid, in_ready, occupancy
   );
endinterface

// File: rtl/pipe_stage_chain_stage.sv
// One pipeline stage: a data+valid register whose next value is picked by the stage select.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int unsigned     WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  stage_sel_e       sel,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   logic [WIDTH:0] reg_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_q <= {1'b0, RESET_VAL};
      end else begin
         case (sel)
            SEL_HOLD:   reg_q <= reg_q;
            SEL_LOAD:   reg_q <= {load_valid, load_data};
            default:    reg_q <= {1'b0, RESET_VAL};
         endcase
      end
   end

   assign data  = reg_q[WIDTH-1:0];
   assign valid = reg_q[WIDTH];

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline shift chain with per-stage valid, stall boundary with bubble,
// per-stage flush and registered occupancy.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   pipe_stage_chain_if.slave bus
);

   localparam int unsigned HW = $clog2(DEPTH + 1);

   logic [HW-1:0]    h_eff;
   stage_sel_e       sel [DEPTH];
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [WIDTH-1:0] ld_data [DEPTH];
   logic [DEPTH-1:0] ld_valid;
   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] valid_nxt;
   logic [HW-1:0]    occupancy_q;

   assign h_eff        = HW'(clamp_hold(32'(bus.hold_upto), DEPTH));
   assign bus.in_ready = (h_eff == '0);

   // Flush beats hold beats bubble beats load.
   always_comb begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
         sel[k] = SEL_LOAD;
         if (bus.flush[k]) begin
            sel[k] = SEL_FLUSH;
         end else if (k < 32'(h_eff)) begin
            sel[k] = SEL_HOLD;
         end else if ((k == 32'(h_eff)) && (h_eff != '0)) begin
            sel[k] = SEL_BUBBLE;
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign ld_data[k]  = bus.in;
         assign ld_valid[k] = bus.in_valid;
      end else begin : g_body
         assign ld_data[k]  = stage_data[k-1];
         assign ld_valid[k] = stage_valid[k-1];
      end

      assign valid_nxt[k] = (sel[k] == SEL_LOAD) ? ld_valid[k] :
                            (sel[k] == SEL_HOLD) ? stage_valid[k] : 1'b0;

      pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk        (clk),
         .reset      (reset),
         .sel        (sel[k]),
         .load_data  (ld_data[k]),
         .load_valid (ld_valid[k]),
         .data       (stage_data[k]),
         .valid      (stage_valid[k])
      );

      assign bus.out[k] = stage_data[k];
   end

   // Counting the next-state vector keeps occupancy aligned with out_valid after each edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occupancy_q <= '0;
      end else begin
         occupancy_q <= HW'(popcount(64'(valid_nxt)));
      end
   end

   assign bus.out_valid = stage_valid;
   assign bus.occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed scoreboard bench for pipe_stage_chain (DEPTH=4, WIDTH=32, RESET_VAL=0).
module tb_pipe_stage_chain;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   typedef struct {
      string        name;
      logic [127:0] out;
      logic [3:0]   vld;
      logic [2:0]   occ;
   } exp_t;

   exp_t exp_q[$];

   pipe_stage_chain_if #(.WIDTH(32), .DEPTH(4)) bus ();

   pipe_stage_chain #(
      .WIDTH     (32),
      .DEPTH     (4),
      .RESET_VAL (32'h0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic check_state(input string nm, input logic [127:0] eo,
                              input logic [3:0] ev, input logic [2:0] eoc);
      cmp({nm, ".out"}, bus.out, eo);
      cmp({nm, ".valid"}, 128'(bus.out_valid), 128'(ev));
      cmp({nm, ".occ"}, 128'(bus.occupancy), 128'(eoc));
   endtask

   // Monitor: after each rising edge, compare any pending expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_state(e.name, e.out, e.vld, e.occ);
         end
      end
   end

   task automatic step(input logic [31:0] d, input logic v, input logic [2:0] h,
                       input logic [3:0] f, input logic exp_rdy, input string nm,
                       input logic [127:0] eo, input logic [3:0] ev, input logic [2:0] eoc);
      exp_t e;
      @(negedge clk);
      bus.in        = d;
      bus.in_valid  = v;
      bus.hold_upto = h;
      bus.flush     = f;
      #1;
      cmp({nm, ".in_ready"}, 128'(bus.in_ready), 128'(exp_rdy));
      e.name = nm;
      e.out  = eo;
      e.vld  = ev;
      e.occ  = eoc;
      exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic pulse_reset(input string nm);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_state({nm, ".async"}, 128'h0, 4'b0000, 3'd0);
      @(posedge clk);
      #1;
      check_state({nm, ".held"}, 128'h0, 4'b0000, 3'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic fill(input string nm);
      step(32'hA0, 1'b1, 3'd0, 4'b0000, 1'b1, {nm, ".f1"},
           {32'h0, 32'h0, 32'h0, 32'hA0}, 4'b0001, 3'd1);
      step(32'hA1, 1'b1, 3'd0, 4'b0000, 1'b1, {nm, ".f2"},
           {32'h0, 32'h0, 32'hA0, 32'hA1}, 4'b0011, 3'd2);
      step(32'hA2, 1'b1, 3'd0, 4'b0000, 1'b1, {nm, ".f3"},
           {32'h0, 32'hA0, 32'hA1, 32'hA2}, 4'b0111, 3'd3);
      step(32'hA3, 1'b1, 3'd0, 4'b0000, 1'b1, {nm, ".f4"},
           {32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4'b1111, 3'd4);
   endtask

   localparam logic [127:0] FULL = {32'hA0, 32'hA1, 32'hA2, 32'hA3};

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b0;
      bus.in        = '0;
      bus.in_valid  = 1'b0;
      bus.hold_upto = '0;
      bus.flush     = '0;
      #3;
      check_state("reset", 128'h0, 4'b0000, 3'd0);
      @(negedge clk);
      reset = 1'b1;

      fill("fill");

      step(32'hB0, 1'b1, 3'd2, 4'b0000, 1'b0, "stall",
           {32'hA1, 32'h0, 32'hA2, 32'hA3}, 4'b1011, 3'd3);

      pulse_reset("rst_a");
      fill("refill_a");
      step(32'hB0, 1'b1, 3'd0, 4'b0011, 1'b1, "squash",
           {32'hA1, 32'hA2, 32'h0, 32'h0}, 4'b1100, 3'd2);

      pulse_reset("rst_b");
      fill("refill_b");
      step(32'hB0, 1'b1, 3'd2, 4'b0001, 1'b0, "flush_hold",
           {32'hA1, 32'h0, 32'hA2, 32'h0}, 4'b1010, 3'd2);

      pulse_reset("rst_c");
      fill("refill_c");
      step(32'hB0, 1'b1, 3'd4, 4'b0000, 1'b0, "sat4", FULL, 4'b1111, 3'd4);
      step(32'hB1, 1'b1, 3'd7, 4'b0000, 1'b0, "sat7", FULL, 4'b1111, 3'd4);
      step(32'hC5, 1'b0, 3'd0, 4'b0000, 1'b1, "invalid_in",
           {32'hA1, 32'hA2, 32'hA3, 32'hC5}, 4'b1110, 3'd3);

      pulse_reset("rst_end");

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog elapsed=20000 required=finish");
      $fatal(1, "timeout");
   end

endmodule
